// File: rtl/hamming84_pkg.sv
// Shared extended-Hamming (8,4) definitions: widths, stream FSM states,
// parity-bit positions and the nibble encoder reused by the decoder side.
package hamming84_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CW_W   = 8;

   // Parity-bit positions within the codeword; data occupies [7:4].
   localparam int unsigned P0_POS = 0;
   localparam int unsigned P1_POS = 1;
   localparam int unsigned P2_POS = 2;
   localparam int unsigned P3_POS = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_t;

   function automatic logic [CW_W-1:0] hamming84_encode(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] cw;
      cw         = '0;
      cw[7:4]    = d;
      cw[P3_POS] = d[3] ^ d[2] ^ d[1];
      cw[P2_POS] = d[3] ^ d[2] ^ d[0];
      cw[P1_POS] = d[3] ^ d[1] ^ d[0];
      // Overall parity makes the full codeword even weight.
      cw[P0_POS] = ^cw[7:1];
      return cw;
   endfunction

endpackage

// File: rtl/hamming84_enc_comb.sv
// Purely combinational nibble to extended-Hamming (8,4) codeword encoder.
module hamming84_enc_comb
   import hamming84_pkg::*;
(
   input  logic [DATA_W-1:0] nibble,
   output logic [CW_W-1:0]   codeword_c
);

   assign codeword_c = hamming84_encode(nibble);

endmodule

// File: rtl/hamming_enc_byte_stream.sv
// Streaming byte to two-codeword (8,4) encoder, low nibble first.
// Optional HAMMING_ENC_ERR_INJECT_EN adds inj_en/inj_mask error injection.
module hamming_enc_byte_stream
   import hamming84_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW_W-1:0]  out_codeword,
   output logic             out_last,
`ifdef HAMMING_ENC_ERR_INJECT_EN
   input  logic             inj_en,
   input  logic [CW_W-1:0]  inj_mask,
`endif
   output logic [CNT_W-1:0] cw_count
);

   state_t              state;
   state_t              state_nxt;
   logic                valid_nxt;
   logic [CW_W-1:0]     cw_nxt;
   logic                last_nxt;
   logic [DATA_W-1:0]   hi_nib;
   logic [DATA_W-1:0]   hi_nxt;
   logic [CW_W-1:0]     hi_mask;
   logic [CW_W-1:0]     hmask_nxt;
   logic [CW_W-1:0]     lo_mask;
   logic [DATA_W-1:0]   enc_nibble;
   logic [CW_W-1:0]     enc_cw_c;
   logic                out_fire;
   logic [CNT_W-1:0]    cnt_nxt;

`ifdef HAMMING_ENC_ERR_INJECT_EN
   assign lo_mask = inj_en ? inj_mask : '0;
`else
   assign lo_mask = '0;
`endif

   // Single shared encoder: high nibble only while presenting the low codeword.
   assign enc_nibble = (state == SEND_LO) ? hi_nib : in_data[DATA_W-1:0];

   hamming84_enc_comb u_enc (
      .nibble     (enc_nibble),
      .codeword_c (enc_cw_c)
   );

   assign in_ready = rst_n && ((state == IDLE) || ((state == SEND_HI) && out_ready));
   assign out_fire = out_valid && out_ready;
   assign cnt_nxt  = (out_fire && (cw_count != '1)) ? cw_count + CNT_W'(1) : cw_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next values of every output register.
   always_comb begin
      state_nxt = state;
      valid_nxt = out_valid;
      cw_nxt    = out_codeword;
      last_nxt  = out_last;
      hi_nxt    = hi_nib;
      hmask_nxt = hi_mask;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = SEND_LO;
               valid_nxt = 1'b1;
               cw_nxt    = enc_cw_c ^ lo_mask;
               last_nxt  = 1'b0;
               hi_nxt    = in_data[7:4];
               hmask_nxt = lo_mask;
            end
         end
         SEND_LO: begin
            if (out_ready) begin
               state_nxt = SEND_HI;
               cw_nxt    = enc_cw_c ^ hi_mask;
               last_nxt  = 1'b1;
            end
         end
         SEND_HI: begin
            if (out_ready) begin
               if (in_valid) begin
                  state_nxt = SEND_LO;
                  valid_nxt = 1'b1;
                  cw_nxt    = enc_cw_c ^ lo_mask;
                  last_nxt  = 1'b0;
                  hi_nxt    = in_data[7:4];
                  hmask_nxt = lo_mask;
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_codeword <= '0;
         out_last     <= 1'b0;
         hi_nib       <= '0;
         hi_mask      <= '0;
         cw_count     <= '0;
      end else begin
         out_valid    <= valid_nxt;
         out_codeword <= cw_nxt;
         out_last     <= last_nxt;
         hi_nib       <= hi_nxt;
         hi_mask      <= hmask_nxt;
         cw_count     <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_hamming_enc_byte_stream.sv
// Self-checking bench: directed literal cases plus randomized traffic
// compared every cycle against a queue-based codeword model.
module tb_hamming_enc_byte_stream;

   localparam int unsigned CNT_W = 5;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_codeword;
   logic             out_last;
   logic [CNT_W-1:0] cw_count;
`ifdef HAMMING_ENC_ERR_INJECT_EN
   logic             inj_en;
   logic [7:0]       inj_mask;
`endif

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   hamming_enc_byte_stream #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_codeword (out_codeword),
      .out_last     (out_last),
`ifdef HAMMING_ENC_ERR_INJECT_EN
      .inj_en       (inj_en),
      .inj_mask     (inj_mask),
`endif
      .cw_count     (cw_count)
   );

   // Reference encoding: parity bits are XORs over the listed data-bit groups.
   function automatic logic [7:0] model_enc(input logic [3:0] d);
      logic [2:0] p;
      p[2] = ^(d & 4'b1110);
      p[1] = ^(d & 4'b1101);
      p[0] = ^(d & 4'b1011);
      return {d, p, ^{d, p}};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of codewords not yet accepted downstream.
   logic [7:0] q[$];
   int         mcount = 0;

   always @(negedge clk) begin
      logic       exp_rdy;
      logic [7:0] m;
      if (mon_en) begin
         exp_rdy = rst_n && ((q.size() == 0) || ((q.size() == 1) && out_ready));
         chk("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("mon_codeword", 32'(out_codeword), 32'(q[0]));
            chk("mon_last", 32'(out_last), 32'(q.size() == 1));
         end
         chk("mon_cw_count", 32'(cw_count), 32'(mcount));
         if (!rst_n) begin
            q.delete();
            mcount = 0;
         end else begin
            if (q.size() != 0 && out_ready) begin
               void'(q.pop_front());
               if (mcount < int'(CNT_MAX)) mcount++;
            end
            if (in_valid && exp_rdy) begin
               m = 8'h00;
`ifdef HAMMING_ENC_ERR_INJECT_EN
               if (inj_en) m = inj_mask;
`endif
               q.push_back(model_enc(in_data[3:0]) ^ m);
               q.push_back(model_enc(in_data[7:4]) ^ m);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      out_ready = 1'b1;
`ifdef HAMMING_ENC_ERR_INJECT_EN
      inj_en    = 1'b0;
      inj_mask  = 8'h00;
`endif
      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_codeword", 32'(out_codeword), 32'h00);
      chk("rst_cw_count", 32'(cw_count), 32'd0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Single byte 0xA5
      send_byte(8'hA5);
      @(negedge clk);
      chk("a5_lo", 32'(out_codeword), 32'h5A);
      chk("a5_lo_last", 32'(out_last), 32'd0);
      @(negedge clk);
      chk("a5_hi", 32'(out_codeword), 32'hA5);
      chk("a5_hi_last", 32'(out_last), 32'd1);
      @(negedge clk);
      chk("a5_idle", 32'(out_valid), 32'd0);
      chk("a5_count", 32'(cw_count), 32'd2);

      // Nibble 0xD and all-ones
      @(posedge clk); #1;
      send_byte(8'h0D);
      @(negedge clk);
      chk("0d_lo", 32'(out_codeword), 32'hD4);
      @(negedge clk);
      chk("0d_hi", 32'(out_codeword), 32'h00);
      @(posedge clk); #1;
      send_byte(8'hFF);
      @(negedge clk);
      chk("ff_lo", 32'(out_codeword), 32'hFF);
      @(negedge clk);
      chk("ff_hi", 32'(out_codeword), 32'hFF);
      @(negedge clk);
      chk("ff_count", 32'(cw_count), 32'd6);

      // Backpressure holds the low codeword
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_byte(8'h3C);
      in_valid = 1'b1;
      in_data  = 8'h77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_codeword", 32'(out_codeword), 32'hC3);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back bytes 0x12, 0x34
      in_valid = 1'b1;
      in_data  = 8'h12;
      begin
         bit ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) chk("b2b_timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      in_data = 8'h34;
      @(negedge clk);
      chk("b2b_cw0", 32'({out_valid, out_last, out_codeword}), 32'h22B);
      chk("b2b_rdy0", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("b2b_cw1", 32'({out_valid, out_last, out_codeword}), 32'h317);
      chk("b2b_rdy1", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_cw2", 32'({out_valid, out_last, out_codeword}), 32'h24D);
      @(negedge clk);
      chk("b2b_cw3", 32'({out_valid, out_last, out_codeword}), 32'h33C);
      chk("b2b_rdy3", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("b2b_idle", 32'(out_valid), 32'd0);

      // Reset during SEND_LO drops the pending high nibble
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_byte(8'h9E);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid_valid", 32'(out_valid), 32'd0);
      end

`ifdef HAMMING_ENC_ERR_INJECT_EN
      @(posedge clk); #1;
      inj_en   = 1'b1;
      inj_mask = 8'h5E;
      send_byte(8'h0D);
      inj_en   = 1'b0;
      @(negedge clk);
      chk("inj_lo", 32'(out_codeword), 32'h8A);
      @(negedge clk);
      chk("inj_hi", 32'(out_codeword), 32'h5E);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         rst_n     = ($urandom_range(0, 99) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef HAMMING_ENC_ERR_INJECT_EN
         inj_en    = ($urandom_range(0, 3) == 0);
         inj_mask  = 8'($urandom);
`endif
      end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);

      // Counter saturation
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         in_data = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat_count", 32'(cw_count), 32'(CNT_MAX));

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hamming_enc_byte_stream.md
Name: hamming_enc_byte_stream

Overview:
- Streaming extended-Hamming (8,4) encoder; forward counterpart of the decoder matrix multiplier.
- Accepts one data byte per valid/ready handshake and splits it into two nibbles, low nibble first.
- Emits one registered 8-bit codeword per nibble on a valid/ready output.
- Sits between the byte source and the channel/error model that feeds the decoder.

Parameters:
- CNT_W, 16, width of the saturating emitted-codeword counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- in_data  in  8  data byte; [3:0] sent first, [7:4] second.
- out_valid  out  1  out_codeword valid.
- out_ready  in  1  downstream accepts this cycle.
- out_codeword  out  8  encoded nibble.
- out_last  out  1  high when out_codeword carries the high nibble.
- cw_count  out  CNT_W  codewords accepted downstream, saturating.

Behaviour:
- Codeword layout, for nibble d[3:0]:
  - cw[7:4] = d[3:0].
  - cw[3] = d3^d2^d1.
  - cw[2] = d3^d2^d0.
  - cw[1] = d3^d1^d0.
  - cw[0] = XOR of cw[7:1] (even overall parity).
  - Encoding is a shared combinational function.
- Transfers occur on a rising edge when valid && ready.
- Reset (rst_n=0 at a rising edge) forces:
  - state=IDLE
  - out_valid=0, out_codeword=0, out_last=0
  - cw_count=0
  - held high nibble=0
  - Reset mid-transfer discards any pending nibble, with no partial output afterwards.
- in_ready is combinational: (state==IDLE) || (state==SEND_HI && out_ready). It is 0 during reset.
- State machine:
  - IDLE: out_valid=0. On byte accept, load out_codeword=enc(in_data[3:0]), out_last=0, store in_data[7:4], go SEND_LO.
  - SEND_LO: out_valid=1; hold outputs while out_ready=0. On accept, load enc(hi nibble), out_last=1, go SEND_HI.
  - SEND_HI: out_valid=1; hold while out_ready=0. On accept:
    - if in_valid is also high in the same cycle, take the new byte and go SEND_LO (back-to-back, no bubble);
    - otherwise go IDLE.
- Timing:
  - Latency: byte accepted at edge N gives low codeword valid after edge N; high codeword valid after the next output accept.
  - Peak throughput: one byte per 2 cycles, one codeword per cycle.
- Outputs are stable while out_valid && !out_ready (AXI-style hold rule).
- in_valid in SEND_LO, or in SEND_HI without out_ready, is ignored and the byte is not consumed.
- cw_count increments by 1 per output accept and saturates at all-ones, with no wrap.

Optional Feature:
- Macro: HAMMING_ENC_ERR_INJECT_EN.
- When defined, adds two ports:
  - inj_en  in  1
  - inj_mask  in  8
- Both are sampled at byte accept. If inj_en=1, inj_mask is XORed into both codewords of that byte. cw_count is unaffected.
- When undefined, the ports are absent and output is the pure encoding.
- Purpose: produce codeword_with_errors stimulus for the decoder.

Decomposition:
- Shared package hamming84_pkg holds:
  - constants DATA_W=4, CW_W=8;
  - typedef enum state_t {IDLE, SEND_LO, SEND_HI};
  - function hamming84_encode(nibble) returning 8 bits;
  - the parity-bit position constants the decoder reuses.
- One natural sub-module, hamming84_enc_comb: a purely combinational nibble-to-codeword block, instantiated once and muxed between the low and high nibble.
- The FSM, output registers and counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_codeword=0x00, cw_count=0.
- Single byte: in_data=0xA5, out_ready=1 ->
  - out_codeword=0x5A with out_last=0;
  - next cycle 0xA5 with out_last=1;
  - cw_count=2; then IDLE.
- Nibble 0xD: in_data=0x0D ->
  - 0xD4 (decoder must return 1101), then 0x00;
  - in_data=0xFF -> 0xFF, 0xFF.
- Backpressure: send 0x3C, hold out_ready=0 for 5 cycles -> out_codeword stays 0xC3 (enc of 0xC) with out_valid=1, and in_ready stays 0 throughout.
- Back-to-back: in_valid=1 continuously with bytes 0x12, 0x34, out_ready=1 -> four codewords on consecutive cycles with no bubble; in_ready pulses in the SEND_HI cycles. Reset asserted mid-SEND_LO -> next cycle out_valid=0 and the high nibble is never emitted.
- With HAMMING_ENC_ERR_INJECT_EN, in_data=0x0D, inj_en=1, inj_mask=0x5E -> codewords 0x8A then 0x5E. Also force cw_count to saturation and check it holds at all-ones.
